// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use/branch stall-flush control and a bounded
// data-memory wait tracker with sticky timeout flag and saturating event counters.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          mem_busy, ms, lu, br, timeout_hit;

    // Memory stage has priority over Writeback; x0 is hard-wired and never forwarded
    always_comb begin
        ForwardA_E = (RegWriteM && RD_M != 5'd0 && RD_M == RS1_E) ? 2'b10 :
                     (RegWriteW && RD_W != 5'd0 && RD_W == RS1_E) ? 2'b01 : 2'b00;
        ForwardB_E = (RegWriteM && RD_M != 5'd0 && RD_M == RS2_E) ? 2'b10 :
                     (RegWriteW && RD_W != 5'd0 && RD_W == RS2_E) ? 2'b01 : 2'b00;
    end

    // Reset masks the memory stall so the pipeline is released immediately
    always_comb begin
        mem_busy    = MemReqM && !MemReadyM;
        ms          = rst && mem_busy && wait_cnt != TO;
        timeout_hit = state == MEM_WAIT && mem_busy && wait_cnt == TO;
        br          = !ms && PCSrcE;
        lu          = !ms && !PCSrcE && ResultSrcE && RD_E != 5'd0 &&
                      (RD_E == RS1_D || RD_E == RS2_D);
        StallF      = ms || lu;
        StallD      = ms || lu;
        StallE      = ms;
        StallM      = ms;
        FlushD      = br;
        FlushE      = br || lu;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state      <= ms ? MEM_WAIT : RUN;
            wait_cnt   <= ms ? wait_cnt + 1'b1 : '0;
            MemTimeout <= MemTimeout || timeout_hit;
            StallCount <= (StallF && !(&StallCount)) ? StallCount + 1'b1 : StallCount;
            FlushCount <= (FlushD && !(&FlushCount)) ? FlushCount + 1'b1 : FlushCount;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus randomized traffic checked against a cycle model.
module tb_hazard_unit;
    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
    logic [CW-1:0] StallCount, FlushCount;

    int tests = 0;
    int fails = 0;
    int m_wait, m_sc, m_fc;
    bit m_to;

    hazard_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RD_M(RD_M), .RD_W(RD_W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .MemTimeout(MemTimeout),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    logic [9:0] dut_comb;
    logic [5:0] dut_ctl;
    logic [8:0] dut_reg;
    assign dut_comb = {ForwardA_E, ForwardB_E, StallF, StallD, StallE, StallM, FlushD, FlushE};
    assign dut_ctl  = {StallF, StallD, StallE, StallM, FlushD, FlushE};
    assign dut_reg  = {MemTimeout, StallCount, FlushCount};

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
        if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {fa, fb, StallF, StallD, StallE, StallM, FlushD, FlushE}
    function automatic logic [9:0] m_comb();
        bit ms, br, lu;
        ms = rst && MemReqM && !MemReadyM && m_wait < TO;
        br = !ms && PCSrcE;
        lu = !ms && !PCSrcE && ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
        return {m_fwd(RS1_E), m_fwd(RS2_E), ms | lu, ms | lu, ms, ms, br, br | lu};
    endfunction

    function automatic logic [8:0] m_reg();
        return {m_to, 4'(m_sc), 4'(m_fc)};
    endfunction

    task automatic model_clear();
        m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic tick();
        logic [9:0] e;
        e = m_comb();
        if (rst) begin
            if (MemReqM && !MemReadyM && m_wait == TO) m_to = 1;
            m_wait = e[3] ? m_wait + 1 : 0;
            if (e[5] && m_sc < CMAX) m_sc++;
            if (e[1] && m_fc < CMAX) m_fc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
        {ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        #2 rst = 1'b0;
        model_clear();
        #1;
        tests++;
        if (dut_comb !== 10'd0) begin fails++; $display("FAIL reset_idle comb=%b want=%b", dut_comb, 10'd0); end
        tests++;
        if (dut_reg !== 9'd0) begin fails++; $display("FAIL reset_regs regs=%h want=0", dut_reg); end
        MemReqM = 1'b1;
        RegWriteM = 1'b1; RD_M = 5'd3; RS1_E = 5'd3;
        #1;
        tests++;
        if (dut_comb !== 10'b10_00_000000) begin fails++; $display("FAIL reset_ms_masked comb=%b want=%b", dut_comb, 10'b10_00_000000); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
    endtask

    task automatic test_forwarding();
        do_reset();
        RS1_E = 5'd3; RD_M = 5'd3; RegWriteM = 1'b1; RD_W = 5'd3; RegWriteW = 1'b1;
        #1;
        tests++;
        if (ForwardA_E !== 2'b10) begin fails++; $display("FAIL fwd_mem got=%b want=10", ForwardA_E); end
        RegWriteM = 1'b0;
        #1;
        tests++;
        if (ForwardA_E !== 2'b01) begin fails++; $display("FAIL fwd_wb got=%b want=01", ForwardA_E); end
        RS1_E = 5'd0; RD_M = 5'd0; RegWriteM = 1'b1; RD_W = 5'd0;
        #1;
        tests++;
        if (ForwardA_E !== 2'b00) begin fails++; $display("FAIL fwd_x0 got=%b want=00", ForwardA_E); end
        RS2_E = 5'd7; RD_W = 5'd7; RD_M = 5'd9;
        #1;
        tests++;
        if (ForwardB_E !== 2'b01) begin fails++; $display("FAIL fwd_b_wb got=%b want=01", ForwardB_E); end
        RD_M = 5'd7;
        #1;
        tests++;
        if (ForwardB_E !== 2'b10) begin fails++; $display("FAIL fwd_b_mem got=%b want=10", ForwardB_E); end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE = 1'b1; RD_E = 5'd5; RS2_D = 5'd5;
        #1;
        tests++;
        if (dut_ctl !== 6'b110001) begin fails++; $display("FAIL lu_ctl got=%b want=110001", dut_ctl); end
        tick();
        idle();
        #1;
        tests++;
        if (dut_ctl !== 6'b000000) begin fails++; $display("FAIL lu_release got=%b want=000000", dut_ctl); end
        tests++;
        if (StallCount !== 4'd1) begin fails++; $display("FAIL lu_count got=%0d want=1", StallCount); end
        ResultSrcE = 1'b1; RD_E = 5'd0; RS1_D = 5'd0;
        #1;
        tests++;
        if (dut_ctl !== 6'b000000) begin fails++; $display("FAIL lu_x0 got=%b want=000000", dut_ctl); end
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        PCSrcE = 1'b1;
        #1;
        tests++;
        if (dut_ctl !== 6'b000011) begin fails++; $display("FAIL br_ctl got=%b want=000011", dut_ctl); end
        tick();
        idle();
        #1;
        tests++;
        if (FlushCount !== 4'd1) begin fails++; $display("FAIL br_count got=%0d want=1", FlushCount); end
        PCSrcE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd4; RS1_D = 5'd4;
        #1;
        tests++;
        if (dut_ctl !== 6'b000011) begin fails++; $display("FAIL br_lu_ctl got=%b want=000011", dut_ctl); end
        tick();
        idle();
        #1;
        tests++;
        if ({StallCount, FlushCount} !== {4'd0, 4'd2}) begin
            fails++; $display("FAIL br_lu_counts stall=%0d flush=%0d want 0/2", StallCount, FlushCount);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin PCSrcE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd6; RS1_D = 5'd6; end
            #1;
            tests++;
            if (dut_ctl !== 6'b111100) begin fails++; $display("FAIL mw_stall[%0d] got=%b want=111100", i, dut_ctl); end
            tick();
        end
        MemReadyM = 1'b1;
        #1;
        tests++;
        if (dut_ctl !== 6'b000011) begin fails++; $display("FAIL mw_ready got=%b want=000011", dut_ctl); end
        tick();
        idle();
        #1;
        tests++;
        if (dut_reg !== {1'b0, 4'd3, 4'd1}) begin fails++; $display("FAIL mw_regs got=%h want=%h", dut_reg, {1'b0, 4'd3, 4'd1}); end
        MemReqM = 1'b1; MemReadyM = 1'b1;
        #1;
        tests++;
        if (dut_ctl !== 6'b000000) begin fails++; $display("FAIL mw_ready_first got=%b want=000000", dut_ctl); end
        tick();
        idle();
        #1;
        tests++;
        if (StallCount !== 4'd3) begin fails++; $display("FAIL mw_ready_first_cnt got=%0d want=3", StallCount); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick(); tick();
        MemReadyM = 1'b1;
        tick();
        MemReadyM = 1'b0;
        for (int i = 0; i < TO; i++) begin
            #1;
            tests++;
            if (StallF !== 1'b1) begin fails++; $display("FAIL b2b_stall[%0d] got=%b want=1", i, StallF); end
            tick();
        end
        #1;
        tests++;
        if (StallF !== 1'b0) begin fails++; $display("FAIL b2b_timeout_drop got=%b want=0", StallF); end
        idle();
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < TO; i++) begin
            #1;
            tests++;
            if (dut_ctl !== 6'b111100) begin fails++; $display("FAIL to_stall[%0d] got=%b want=111100", i, dut_ctl); end
            tick();
        end
        #1;
        tests++;
        if ({dut_ctl, MemTimeout} !== 7'd0) begin fails++; $display("FAIL to_drop ctl=%b to=%b want 0", dut_ctl, MemTimeout); end
        tick();
        idle();
        #1;
        tests++;
        if (dut_reg !== {1'b1, 4'd4, 4'd0}) begin fails++; $display("FAIL to_flag got=%h want=%h", dut_reg, {1'b1, 4'd4, 4'd0}); end
        repeat (3) tick();
        tests++;
        if (MemTimeout !== 1'b1) begin fails++; $display("FAIL to_sticky got=%b want=1", MemTimeout); end
        rst = 1'b0;
        model_clear();
        #1;
        tests++;
        if (MemTimeout !== 1'b0) begin fails++; $display("FAIL to_rst_clear got=%b want=0", MemTimeout); end
        #2 rst = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ResultSrcE = 1'b1; RD_E = 5'd8; RS1_D = 5'd8;
            tick();
            idle();
            tick();
        end
        tests++;
        if (StallCount !== 4'hF) begin fails++; $display("FAIL sat_count got=%0d want=15", StallCount); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_clear();
        #1;
        tests++;
        if ({dut_ctl, dut_reg} !== 15'd0) begin fails++; $display("FAIL rmw_drop ctl=%b regs=%h want 0", dut_ctl, dut_reg); end
        repeat (6) tick();
        MemReqM = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if (dut_reg !== 9'd0) begin fails++; $display("FAIL rmw_no_timeout regs=%h want 0", dut_reg); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
            RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
            RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
            RD_W  = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 7) == 0);
            MemReqM    = ($urandom_range(0, 2) != 0);
            MemReadyM  = ($urandom_range(0, 4) == 0);
            #1;
            tests++;
            if (dut_comb !== m_comb()) begin fails++; $display("FAIL rand_comb[%0d] got=%b want=%b", i, dut_comb, m_comb()); end
            tests++;
            if (dut_reg !== m_reg()) begin fails++; $display("FAIL rand_regs[%0d] got=%h want=%h", i, dut_reg, m_reg()); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        model_clear();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
